// File: rtl/max7219_pkg.sv
// Shared register map, FSM state type and frame helper for the MAX7219 serializer.
package max7219_pkg;

   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCAN      = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_TEST      = 4'hF;

   localparam int INIT_CMDS = 5;

   typedef enum logic [1:0] {
      INIT_LOAD,
      SHIFT,
      LATCH,
      IDLE
   } state_e;

   function automatic logic [15:0] make_frame(input logic [3:0] addr, input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

endpackage

// File: rtl/max7219_serializer_if.sv
// Row-data handshake between the pixel provider (master) and the serializer (slave).
interface max7219_serializer_if;

   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [2:0] row_idx;
   logic       init_done;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready,
      input  row_idx,
      input  init_done
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready,
      output row_idx,
      output init_done
   );

endinterface

// File: rtl/max7219_shift.sv
// 16-bit MSB-first serializer with CLK_DIV bit-clock divider and trailing LOAD pulse.
module max7219_shift #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] frame,
   output logic        max_din,
   output logic        max_clk,
   output logic        max_cs,
   output logic        shift_done,
   output logic        latch_done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SHIFT,
      PH_LATCH
   } phase_e;

   phase_e           phase;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       bit_cnt;
   logic [15:0]      shreg;
   logic             div_end;
   logic             bit_end;

   assign div_end    = (div_cnt == DIV_MAX);
   // A bit ends when the high half of max_clk expires.
   assign bit_end    = (phase == PH_SHIFT) && div_end && max_clk;
   assign shift_done = bit_end && (bit_cnt == 4'd15);
   assign latch_done = (phase == PH_LATCH) && div_end;

   always_ff @(posedge clk) begin
      if (phase == PH_IDLE && start)
         shreg <= {frame[14:0], 1'b0};
      else if (bit_end)
         shreg <= {shreg[14:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= PH_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         max_din <= 1'b0;
         max_clk <= 1'b0;
         max_cs  <= 1'b1;
      end else begin
         unique case (phase)
            PH_IDLE: begin
               if (start) begin
                  phase   <= PH_SHIFT;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  max_din <= frame[15];
                  max_clk <= 1'b0;
                  max_cs  <= 1'b0;
               end
            end
            PH_SHIFT: begin
               if (!div_end) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!max_clk) begin
                     max_clk <= 1'b1;
                  end else begin
                     max_clk <= 1'b0;
                     if (bit_cnt == 4'd15) begin
                        // cs only rises here, so a frame is never cut short by anything but reset
                        max_din <= 1'b0;
                        max_cs  <= 1'b1;
                        phase   <= PH_LATCH;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        max_din <= shreg[15];
                     end
                  end
               end
            end
            PH_LATCH: begin
               if (!div_end) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  phase   <= PH_IDLE;
               end
            end
            default: phase <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/max7219_serializer.sv
// MAX7219 driver: power-up init sequence, then one digit-register frame per accepted row byte.
// Optional MAX7219_INTENSITY_PORT_EN adds a live intensity_in port with automatic re-send on change.
module max7219_serializer
   import max7219_pkg::*;
#(
   parameter int         CLK_DIV    = 4,
   parameter logic [3:0] INTENSITY  = 4'h8,
   parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
   input  logic clk,
   input  logic rst_n,
   max7219_serializer_if.slave up,
`ifdef MAX7219_INTENSITY_PORT_EN
   input  logic [3:0] intensity_in,
`endif
   output logic max_din,
   output logic max_clk,
   output logic max_cs
);

   state_e      state;
   logic [2:0]  init_idx;
   logic        init_done;
   logic [2:0]  row_idx;
   logic        is_data;
   logic        start;
   logic        data_start;
   logic [15:0] frame;
   logic        shift_done;
   logic        latch_done;
   logic        int_match;
   logic [3:0]  init_inten;

`ifdef MAX7219_INTENSITY_PORT_EN
   logic [3:0] int_sent;
   assign int_match  = (intensity_in == int_sent);
   assign init_inten = intensity_in;
`else
   assign int_match  = 1'b1;
   assign init_inten = INTENSITY;
`endif

   function automatic logic [15:0] init_frame(input logic [2:0] idx, input logic [3:0] inten);
      logic [15:0] f;
      case (idx)
         3'd0:    f = make_frame(REG_TEST, 8'h00);
         3'd1:    f = make_frame(REG_DECODE, 8'h00);
         3'd2:    f = make_frame(REG_SCAN, {5'b0, SCAN_LIMIT});
         3'd3:    f = make_frame(REG_INTENSITY, {4'h0, inten});
         default: f = make_frame(REG_SHUTDOWN, 8'h01);
      endcase
      return f;
   endfunction

   assign up.data_ready = (state == IDLE) && init_done && int_match;
   assign up.row_idx    = row_idx;
   assign up.init_done  = init_done;

   always_comb begin
      start      = 1'b0;
      data_start = 1'b0;
      frame      = 16'h0000;
      unique case (state)
         INIT_LOAD: begin
            start = 1'b1;
            frame = init_frame(init_idx, init_inten);
         end
         IDLE: begin
`ifdef MAX7219_INTENSITY_PORT_EN
            // A pending intensity change wins over row data.
            if (!int_match) begin
               start = 1'b1;
               frame = make_frame(REG_INTENSITY, {4'h0, intensity_in});
            end else
`endif
            if (up.data_valid && init_done) begin
               start      = 1'b1;
               data_start = 1'b1;
               frame      = make_frame(REG_DIGIT0 + {1'b0, row_idx}, up.data_in);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT_LOAD;
         init_idx  <= '0;
         init_done <= 1'b0;
         row_idx   <= '0;
         is_data   <= 1'b0;
`ifdef MAX7219_INTENSITY_PORT_EN
         int_sent  <= '0;
`endif
      end else begin
         unique case (state)
            INIT_LOAD: begin
               is_data <= 1'b0;
               state   <= SHIFT;
`ifdef MAX7219_INTENSITY_PORT_EN
               if (init_idx == 3'd3) int_sent <= intensity_in;
`endif
            end
            SHIFT: if (shift_done) state <= LATCH;
            LATCH: begin
               if (latch_done) begin
                  if (is_data) row_idx <= row_idx + 3'd1;
                  if (!init_done && init_idx != 3'(INIT_CMDS - 1)) begin
                     init_idx <= init_idx + 3'd1;
                     state    <= INIT_LOAD;
                  end else begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            IDLE: begin
               if (start) begin
                  is_data <= data_start;
                  state   <= SHIFT;
`ifdef MAX7219_INTENSITY_PORT_EN
                  if (!data_start) int_sent <= intensity_in;
`endif
               end
            end
            default: state <= INIT_LOAD;
         endcase
      end
   end

   max7219_shift #(
      .CLK_DIV(CLK_DIV)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame     (frame),
      .max_din   (max_din),
      .max_clk   (max_clk),
      .max_cs    (max_cs),
      .shift_done(shift_done),
      .latch_done(latch_done)
   );

endmodule

// File: tb/tb_max7219_serializer.sv
// Directed bench for max7219_serializer (CLK_DIV=4): decodes frames off the serial pins.
module tb_max7219_serializer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic max_din, max_clk, max_cs;
`ifdef MAX7219_INTENSITY_PORT_EN
   logic [3:0] intensity_in = 4'h8;
`endif

   always #5 clk = ~clk;

   max7219_serializer_if u_if();

   max7219_serializer #(
      .CLK_DIV(4),
      .INTENSITY(4'h8),
      .SCAN_LIMIT(3'd7)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .up     (u_if),
`ifdef MAX7219_INTENSITY_PORT_EN
      .intensity_in(intensity_in),
`endif
      .max_din(max_din),
      .max_clk(max_clk),
      .max_cs (max_cs)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   // Frame decoder: shift max_din on max_clk rising edges while max_cs is low.
   logic [15:0] sh = '0;
   int nbits = 0, low_cnt = 0, high_cnt = 0;
   logic cs_d = 1'b1, mclk_d = 1'b0;
   logic [15:0] fq[$];
   int lq[$];
   int hq[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         sh = '0; nbits = 0; low_cnt = 0; high_cnt = 0; cs_d = 1'b1; mclk_d = 1'b0;
      end else begin
         if (!max_cs) begin
            if (cs_d) begin
               hq.push_back(high_cnt);
               low_cnt = 0;
               nbits = 0;
            end
            low_cnt++;
            if (max_clk && !mclk_d) begin
               sh = {sh[14:0], max_din};
               nbits++;
            end
         end else begin
            if (!cs_d) begin
               fq.push_back(sh);
               lq.push_back(low_cnt);
               high_cnt = 0;
            end
            high_cnt++;
         end
         cs_d = max_cs;
         mclk_d = max_clk;
      end
   end

   task automatic clear_q();
      fq.delete(); lq.delete(); hq.delete();
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int k = 0;
      while (fq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (fq.size() >= n);
   endtask

   task automatic wait_ready(input int budget, output bit ok);
      int k = 0;
      while (u_if.data_ready !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (u_if.data_ready === 1'b1);
   endtask

   task automatic wait_init(input int budget, output bit ok);
      int k = 0;
      while (u_if.init_done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (u_if.init_done === 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      u_if.data_in = b;
      u_if.data_valid = 1'b1;
      wait_ready(2000, ok);
      @(negedge clk);
      u_if.data_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      u_if.data_valid = 1'b0;
      u_if.data_in = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (max_cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", max_cs); end
      checks++; if (max_clk !== 1'b0) begin failures++; $display("FAIL reset_clk got=%b exp=0", max_clk); end
      checks++; if (max_din !== 1'b0) begin failures++; $display("FAIL reset_din got=%b exp=0", max_din); end
      checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", u_if.data_ready); end
      checks++; if (u_if.init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", u_if.init_done); end
      checks++; if (u_if.row_idx !== 3'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", u_if.row_idx); end
      clear_q();
      rst_n = 1'b1;
   endtask

   task automatic test_init();
      logic [15:0] exp_f[5];
      bit ok;
      exp_f = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A08, 16'h0C01};
      wait_init(2000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL init_done_timeout got=0 exp=1"); end
      checks++; if (fq.size() != 5) begin failures++; $display("FAIL init_frame_count got=%0d exp=5", fq.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (fq[i] !== exp_f[i]) begin failures++; $display("FAIL init_frame%0d got=%h exp=%h", i, fq[i], exp_f[i]); end
         checks++; if (lq[i] != 128) begin failures++; $display("FAIL init_cs_low%0d got=%0d exp=128", i, lq[i]); end
         if (i < 4) begin
            checks++; if (hq[i+1] < 4) begin failures++; $display("FAIL init_cs_high%0d got=%0d exp>=4", i, hq[i+1]); end
         end
      end
   endtask

   task automatic test_stream();
      int acc[8];
      bit ok;
      logic [15:0] exp_v;
      clear_q();
      u_if.data_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         u_if.data_in = 8'(1 << i);
         wait_ready(400, ok);
         checks++; if (!ok) begin failures++; $display("FAIL stream_accept%0d timeout", i); end
         acc[i] = cyc;
         checks++; if (u_if.row_idx !== 3'(i)) begin failures++; $display("FAIL stream_row%0d got=%0d exp=%0d", i, u_if.row_idx, i); end
         @(negedge clk);
         checks++; if (u_if.data_ready !== 1'b0 || max_cs !== 1'b0) begin
            failures++; $display("FAIL stream_after_accept%0d ready=%b cs=%b exp ready=0 cs=0", i, u_if.data_ready, max_cs);
         end
      end
      u_if.data_valid = 1'b0;
      wait_frames(8, 400, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stream_frames timeout got=%0d exp=8", fq.size()); end
      for (int i = 0; i < 8; i++) begin
         exp_v = {4'h0, 4'(i + 1), 8'(1 << i)};
         checks++; if (fq[i] !== exp_v) begin failures++; $display("FAIL stream_frame%0d got=%h exp=%h", i, fq[i], exp_v); end
      end
      for (int i = 1; i < 8; i++) begin
         checks++; if (acc[i] - acc[i-1] != 133) begin failures++; $display("FAIL stream_interval%0d got=%0d exp=133", i, acc[i] - acc[i-1]); end
      end
      wait_ready(400, ok);
      checks++; if (u_if.row_idx !== 3'd0) begin failures++; $display("FAIL stream_row_wrap got=%0d exp=0", u_if.row_idx); end
   endtask

   task automatic test_idle_gap();
      int bad;
      bit ok;
      logic [7:0] bytes[2];
      logic [15:0] exp_v[2];
      bytes = '{8'h5A, 8'h3C};
      exp_v = '{16'h015A, 16'h023C};
      for (int j = 0; j < 2; j++) begin
         bad = 0;
         repeat (50) begin
            @(negedge clk);
            if (max_cs !== 1'b1 || u_if.data_ready !== 1'b1) bad++;
         end
         checks++; if (bad != 0) begin failures++; $display("FAIL gap_idle%0d bad_cycles=%0d exp=0", j, bad); end
         clear_q();
         send_byte(bytes[j], ok);
         wait_frames(1, 400, ok);
         checks++; if (fq[0] !== exp_v[j]) begin failures++; $display("FAIL gap_frame%0d got=%h exp=%h", j, fq[0], exp_v[j]); end
         wait_ready(400, ok);
      end
      checks++; if (u_if.row_idx !== 3'd2) begin failures++; $display("FAIL gap_row got=%0d exp=2", u_if.row_idx); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int k = 0;
      clear_q();
      send_byte(8'h55, ok);
      while (nbits < 8 && k < 400) begin
         @(negedge clk);
         k++;
      end
      checks++; if (nbits < 8) begin failures++; $display("FAIL midrst_reach_bit7 got=%0d exp=8", nbits); end
      rst_n = 1'b0;
      #1;
      checks++; if (max_cs !== 1'b1) begin failures++; $display("FAIL midrst_cs got=%b exp=1", max_cs); end
      checks++; if (max_clk !== 1'b0) begin failures++; $display("FAIL midrst_clk got=%b exp=0", max_clk); end
      repeat (2) @(negedge clk);
      checks++; if (u_if.row_idx !== 3'd0) begin failures++; $display("FAIL midrst_row got=%0d exp=0", u_if.row_idx); end
      checks++; if (fq.size() != 0) begin failures++; $display("FAIL midrst_partial_latched got=%0d exp=0", fq.size()); end
      rst_n = 1'b1;
      wait_frames(1, 400, ok);
      checks++; if (fq[0] !== 16'h0F00) begin failures++; $display("FAIL midrst_first_frame got=%h exp=0f00", fq[0]); end
      wait_init(2000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL midrst_reinit timeout"); end
   endtask

   task automatic test_early_valid();
      int early = 0;
      int accepts = 0;
      int k = 0;
      bit drop = 1'b0;
      rst_n = 1'b0;
      u_if.data_in = 8'hAA;
      u_if.data_valid = 1'b1;
      repeat (3) @(negedge clk);
      clear_q();
      rst_n = 1'b1;
      while (fq.size() < 6 && k < 2500) begin
         @(negedge clk);
         k++;
         if (drop) begin
            u_if.data_valid = 1'b0;
            drop = 1'b0;
         end
         if (u_if.data_ready === 1'b1 && u_if.init_done !== 1'b1) early++;
         if (u_if.data_valid && u_if.data_ready === 1'b1) begin
            accepts++;
            drop = 1'b1;
         end
      end
      u_if.data_valid = 1'b0;
      checks++; if (early != 0) begin failures++; $display("FAIL early_ready_before_init got=%0d exp=0", early); end
      checks++; if (accepts != 1) begin failures++; $display("FAIL early_accepts got=%0d exp=1", accepts); end
      checks++; if (fq[0] !== 16'h0F00) begin failures++; $display("FAIL early_first got=%h exp=0f00", fq[0]); end
      checks++; if (fq[4] !== 16'h0C01) begin failures++; $display("FAIL early_last_init got=%h exp=0c01", fq[4]); end
      checks++; if (fq[5] !== 16'h01AA) begin failures++; $display("FAIL early_data got=%h exp=01aa", fq[5]); end
   endtask

`ifdef MAX7219_INTENSITY_PORT_EN
   task automatic test_intensity();
      bit ok;
      wait_ready(400, ok);
      clear_q();
      u_if.data_in = 8'h11;
      u_if.data_valid = 1'b1;
      intensity_in = 4'h3;
      #1;
      checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL int_ready got=%b exp=0", u_if.data_ready); end
      @(negedge clk);
      wait_ready(400, ok);
      @(negedge clk);
      u_if.data_valid = 1'b0;
      wait_frames(2, 400, ok);
      checks++; if (fq[0] !== 16'h0A03) begin failures++; $display("FAIL int_frame got=%h exp=0a03", fq[0]); end
      checks++; if (fq[1] !== 16'h0211) begin failures++; $display("FAIL int_data_frame got=%h exp=0211", fq[1]); end
   endtask
`endif

   initial begin
      #2ms;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.data_in = 8'h00;
      u_if.data_valid = 1'b0;
      test_reset();
      test_init();
      test_stream();
      test_idle_gap();
      test_reset_mid();
      test_early_valid();
`ifdef MAX7219_INTENSITY_PORT_EN
      test_intensity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/max7219_serializer.md
Name: max7219_serializer

Overview:
- Consumer end of the row-data stream: accepts 8-bit column bytes, one per display row, and serializes each into a MAX7219 16-bit SPI-style frame (DIN/CLK/LOAD).
- Runs a fixed power-up register initialisation, then refreshes digit registers 1..8 in row order.
- Sits between the pixel provider and the MAX7219 pins.

Parameters:
- CLK_DIV, 4: system clocks per max_clk half-period; legal values ≥2.
- INTENSITY, 4'h8: value written to the intensity register.
- SCAN_LIMIT, 3'd7: value written to the scan-limit register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  8  column byte for the current row; bit 7 maps to MAX7219 D7
- data_valid  in  1  data_in is valid
- data_ready  out  1  block accepts a byte this cycle
- row_idx  out  3  row the next accepted byte is written to (0..7)
- init_done  out  1  init sequence complete; stays high until reset
- max_din  out  1  serial data to MAX7219
- max_clk  out  1  serial clock to MAX7219
- max_cs  out  1  LOAD/CS; active low

Behaviour:
- Clocking and reset: single clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values: max_cs=1, max_clk=0, max_din=0, data_ready=0, init_done=0, row_idx=0.
- Reset asserted mid-frame: outputs return to reset values immediately. After release, the init sequence restarts from the first command. A partial frame is never latched, because max_cs does not rise from a shift state except through LATCH.
- Frame format: bits 15..12 = 0, bits 11..8 = register address, bits 7..0 = data. Sent MSB first.
- Bit timing, per bit:
  - max_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - max_din changes only on the cycle max_clk goes low, so it is stable across the rising edge.
  - One frame holds max_cs low for exactly 32*CLK_DIV cycles; max_clk ends low.
- LATCH: max_cs high for CLK_DIV cycles after each frame. Its rising edge loads the MAX7219.
- FSM states: INIT_LOAD, SHIFT, LATCH, IDLE.
- Init sequence (in order):
  - 0x0F00: display test off
  - 0x0900: no decode
  - 0x0B00|SCAN_LIMIT
  - 0x0A00|INTENSITY
  - 0x0C01: normal operation
- Init transitions: INIT_LOAD → SHIFT → LATCH, repeated for each of the 5 commands. After the 5th LATCH, init_done=1 and the FSM goes to IDLE.
- Handshake:
  - data_ready=1 only in IDLE with init_done=1.
  - A transfer occurs on a cycle where data_valid && data_ready.
  - On transfer: the block captures data_in and builds frame {4'h0, row_idx+1, data_in}. On the next cycle data_ready=0, SHIFT is entered and max_cs=0.
  - data_valid while data_ready=0 is ignored; the byte is not buffered. Upstream must hold data_valid until accepted.
- row_idx: increments on each LATCH completion of a data frame and wraps 7 → 0. Init frames do not change it.
- Data throughput: one byte per 33*CLK_DIV+1 cycles (IDLE cycle + shift + latch), given continuous data_valid.

Optional Feature:
- MAX7219_INTENSITY_PORT_EN, defined:
  - Adds input intensity_in[4 bits].
  - The init sequence uses intensity_in instead of INTENSITY.
  - The value last sent is registered. While in IDLE, if intensity_in differs from it, the block sends 0x0A0X (X = intensity_in) before accepting further data; data_ready stays 0 during that frame. This command takes priority over a simultaneous data_valid.
- Not defined: the port is absent and INTENSITY is used only during init.

Decomposition:
- Package max7219_pkg:
  - register addresses: REG_DIGIT0=4'h1, REG_DECODE=4'h9, REG_INTENSITY=4'hA, REG_SCAN=4'hB, REG_SHUTDOWN=4'hC, REG_TEST=4'hF
  - FSM state enum
  - INIT_CMDS count = 5
- Sub-module max7219_shift: 16-bit serializer plus CLK_DIV divider with a start/done interface. It owns max_din, max_clk and max_cs during SHIFT and LATCH.

Test Plan:
- Reset release with CLK_DIV=4: the bench decodes 5 frames on max_din sampled at max_clk rising edges. Required: 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01. Each frame has max_cs low for 128 cycles and high ≥4 cycles. init_done rises after the 5th frame.
- After init, send 8 bytes 0x01,0x02,...,0x80 with data_valid held high. Required frames: 0x0101, 0x0202, ..., 0x0880. row_idx steps 0..7 and returns to 0. Accepts are 133 cycles apart.
- Hold data_valid=1 with data_in=0xAA before init_done. Required: no transfer occurs until init_done=1; then one frame 0x01AA.
- Assert rst_n low at bit 7 of a data frame. Required: max_cs=1 and max_clk=0 immediately. After release, the first frame is 0x0F00 and row_idx=0.
- Drop data_valid for 50 cycles between bytes. Required: max_cs stays high and data_ready stays 1 in IDLE. The next byte is written to the correct next row.
- With MAX7219_INTENSITY_PORT_EN defined, change intensity_in 8→3 while data_valid=1. Required: frame 0x0A03 is sent before the pending data frame.
